// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared types and constants for the pattern scan controller and its match core.
package pattern_scan_pkg;

    localparam int PAT_MAX = 8;
    localparam int FRAME_W = 16;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(PAT_MAX) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Out of reset the detector looks for "0 then 1".
    localparam logic [PAT_MAX-1:0] RST_PAT = PAT_MAX'(2'b01);
    localparam logic [LEN_W-1:0]   RST_LEN = LEN_W'(2);

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Configuration, command, serial stream and status bundle of the pattern scan controller.
interface pattern_scan_ctrl_if;
    import pattern_scan_pkg::*;

    logic                 cfg_we;
    logic [PAT_MAX-1:0]   cfg_pat;
    logic [LEN_W-1:0]     cfg_len;
    logic                 start;
    logic [FRAME_W-1:0]   frame_len;
    logic                 x_valid;
    logic                 x;
    logic                 x_ready;
    logic                 hit;
    logic [CNT_W-1:0]     match_cnt;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output cfg_we, cfg_pat, cfg_len, start, frame_len, x_valid, x,
        input  x_ready, hit, match_cnt, busy, done, err
    );

    modport slave (
        input  cfg_we, cfg_pat, cfg_len, start, frame_len, x_valid, x,
        output x_ready, hit, match_cnt, busy, done, err
    );

endinterface

// File: rtl/pattern_match_core.sv
// Bit-serial match core: history shift register, fill counter and length-masked compare.
// OVERLAP_EN defined keeps fill across matches so matches may overlap.
module pattern_match_core
    import pattern_scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en_i,
    input  logic               bit_i,
    input  logic               clr_i,
    input  logic [PAT_MAX-1:0] pat_i,
    input  logic [LEN_W-1:0]   len_i,
    output logic               match_o
);

    // Only PAT_MAX-1 old bits are kept; the incoming bit completes the compare window.
    logic [PAT_MAX-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [PAT_MAX-1:0] window;
    logic [PAT_MAX-1:0] mask;
    logic [LEN_W:0]     fill_inc;

    assign window   = {hist_q, bit_i};
    assign fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (LEN_W'(i) < len_i);
        end
    end

    assign match_o = shift_en_i
                   && (fill_inc >= {1'b0, len_i})
                   && (((window ^ pat_i) & mask) == '0);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en_i) begin
            hist_d = window[PAT_MAX-2:0];
`ifdef OVERLAP_EN
            if (fill_q != LEN_W'(PAT_MAX)) begin
                fill_d = fill_q + LEN_W'(1);
            end
`else
            if (match_o) begin
                fill_d = '0;
            end else if (fill_q != LEN_W'(PAT_MAX)) begin
                fill_d = fill_q + LEN_W'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Frame-level controller: config/start handling, frame countdown, match counting and status pulses.
// Match overlap behaviour follows OVERLAP_EN inside pattern_match_core.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    pattern_scan_ctrl_if.slave  bus
);

    // state | meaning
    // IDLE  | accept cfg_we and start, validate stored config
    // RUN   | pull frame bits from the serial stream
    // DONE  | one-cycle done pulse, then back to IDLE
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]         state_q, state_d;
    logic [PAT_MAX-1:0] cfg_pat_q, cfg_pat_d;
    logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
    logic [FRAME_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic               hit_q, hit_d;
    logic               err_q, err_d;

    logic cfg_valid;
    logic core_clr;
    logic core_shift;
    logic core_match;

    assign cfg_valid = (cfg_len_q != '0) && (cfg_len_q <= LEN_W'(PAT_MAX));

    pattern_match_core u_core (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (core_shift),
        .bit_i      (bus.x),
        .clr_i      (core_clr),
        .pat_i      (cfg_pat_q),
        .len_i      (cfg_len_q),
        .match_o    (core_match)
    );

    always_comb begin
        state_d     = state_q;
        cfg_pat_d   = cfg_pat_q;
        cfg_len_d   = cfg_len_q;
        remaining_d = remaining_q;
        match_cnt_d = match_cnt_q;
        hit_d       = 1'b0;
        err_d       = 1'b0;
        core_clr    = 1'b0;
        core_shift  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cfg_we) begin
                    cfg_pat_d = bus.cfg_pat;
                    cfg_len_d = bus.cfg_len;
                end
                // start checks the length already stored, not one written this cycle
                if (bus.start) begin
                    if (!cfg_valid) begin
                        err_d = 1'b1;
                    end else begin
                        core_clr    = 1'b1;
                        match_cnt_d = '0;
                        remaining_d = bus.frame_len;
                        state_d     = (bus.frame_len == '0) ? S_DONE : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.x_valid) begin
                    core_shift  = 1'b1;
                    remaining_d = remaining_q - FRAME_W'(1);
                    if (core_match) begin
                        hit_d = 1'b1;
                        if (match_cnt_q != '1) begin
                            match_cnt_d = match_cnt_q + CNT_W'(1);
                        end
                    end
                    if (remaining_q == FRAME_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cfg_pat_q   <= RST_PAT;
            cfg_len_q   <= RST_LEN;
            remaining_q <= '0;
            match_cnt_q <= '0;
            hit_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_pat_q   <= cfg_pat_d;
            cfg_len_q   <= cfg_len_d;
            remaining_q <= remaining_d;
            match_cnt_q <= match_cnt_d;
            hit_q       <= hit_d;
            err_q       <= err_d;
        end
    end

    assign bus.x_ready   = (state_q == S_RUN);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.hit       = hit_q;
    assign bus.err       = err_q;
    assign bus.match_cnt = match_cnt_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl against a stream-level reference model.
module tb_pattern_scan_ctrl;
    import pattern_scan_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pattern_scan_ctrl_if bus_if ();

    pattern_scan_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks = 0;
    int passed = 0;

    // reference model: stored config, accepted bits of the frame, bits since last restart, count
    logic [PAT_MAX-1:0] m_pat;
    int                 m_len;
    logic               m_bits[$];
    int                 m_since;
    int                 m_cnt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic tail_matches();
        for (int i = 0; i < m_len; i++) begin
            if (m_bits[m_bits.size() - 1 - i] !== m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic set_cfg(input logic [PAT_MAX-1:0] pat, input int len);
        bus_if.cfg_we  = 1'b1;
        bus_if.cfg_pat = pat;
        bus_if.cfg_len = LEN_W'(len);
        step();
        bus_if.cfg_we  = 1'b0;
        m_pat = pat;
        m_len = len;
    endtask

    task automatic do_frame(input int n, input logic [511:0] b, input int vmode, input logic disturb);
        int  acc;
        int  cyc;
        logic v;
        logic exp_hit;
        bus_if.start     = 1'b1;
        bus_if.frame_len = FRAME_W'(n);
        step();
        bus_if.start = 1'b0;
        m_bits.delete();
        m_since = 0;
        m_cnt   = 0;
        check("start_busy", bus_if.busy, 1);
        check("start_ready", bus_if.x_ready, (n != 0));
        check("start_done", bus_if.done, (n == 0));
        check("start_cnt", bus_if.match_cnt, 0);
        acc = 0;
        cyc = 0;
        while (acc < n) begin
            if (vmode == 0 || cyc > 4 * n + 8) v = 1'b1;
            else if (vmode == 1) v = (cyc % 2 == 1);
            else v = ($urandom_range(0, 3) != 0);
            bus_if.x_valid = v;
            bus_if.x       = b[acc];
            if (disturb && cyc == 3) begin
                bus_if.cfg_we    = 1'b1;
                bus_if.cfg_pat   = '1;
                bus_if.cfg_len   = LEN_W'(1);
                bus_if.start     = 1'b1;
                bus_if.frame_len = FRAME_W'(7);
            end
            exp_hit = 1'b0;
            if (v) begin
                m_bits.push_back(b[acc]);
                m_since++;
                if (m_since >= m_len && tail_matches()) begin
                    exp_hit = 1'b1;
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
`ifndef OVERLAP_EN
                    m_since = 0;
`endif
                end
                acc++;
            end
            step();
            bus_if.x_valid = 1'b0;
            bus_if.cfg_we  = 1'b0;
            bus_if.start   = 1'b0;
            check("run_hit", bus_if.hit, exp_hit);
            check("run_cnt", bus_if.match_cnt, m_cnt);
            check("run_ready", bus_if.x_ready, (acc < n));
            check("run_done", bus_if.done, (acc == n));
            check("run_busy", bus_if.busy, 1);
            cyc++;
        end
        step();
        check("end_busy", bus_if.busy, 0);
        check("end_done", bus_if.done, 0);
        check("end_hit", bus_if.hit, 0);
        check("end_ready", bus_if.x_ready, 0);
        check("end_cnt_hold", bus_if.match_cnt, m_cnt);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hit"}, bus_if.hit, 0);
        check({tag, "_done"}, bus_if.done, 0);
        check({tag, "_busy"}, bus_if.busy, 0);
        check({tag, "_err"}, bus_if.err, 0);
        check({tag, "_ready"}, bus_if.x_ready, 0);
        check({tag, "_cnt"}, bus_if.match_cnt, 0);
    endtask

    task automatic check_reject(input string tag);
        bus_if.start     = 1'b1;
        bus_if.frame_len = FRAME_W'(5);
        step();
        bus_if.start = 1'b0;
        check({tag, "_err"}, bus_if.err, 1);
        check({tag, "_busy"}, bus_if.busy, 0);
        check({tag, "_ready"}, bus_if.x_ready, 0);
        step();
        check({tag, "_err_pulse"}, bus_if.err, 0);
        check({tag, "_busy2"}, bus_if.busy, 0);
    endtask

    initial begin
        logic [511:0] b;
        bus_if.cfg_we    = 1'b0;
        bus_if.cfg_pat   = '0;
        bus_if.cfg_len   = '0;
        bus_if.start     = 1'b0;
        bus_if.frame_len = '0;
        bus_if.x_valid   = 1'b0;
        bus_if.x         = 1'b0;
        m_pat = PAT_MAX'(2'b01);
        m_len = 2;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_all_zero("reset");

        // default "01" detector on 0,1,1,0,1
        b = '0;
        b[4:0] = 5'b10110;
        do_frame(5, b, 0, 1'b0);
        check("default_cnt", bus_if.match_cnt, 2);

        // 101 on 1,0,1,0,1
        set_cfg(PAT_MAX'(3'b101), 3);
        b = '0;
        b[4:0] = 5'b10101;
        do_frame(5, b, 0, 1'b0);
`ifdef OVERLAP_EN
        check("overlap_cnt", bus_if.match_cnt, 2);
`else
        check("overlap_cnt", bus_if.match_cnt, 1);
`endif

        // empty frame
        do_frame(0, b, 0, 1'b0);

        // invalid lengths
        set_cfg('0, 0);
        check_reject("len0");
        set_cfg('1, 9);
        check_reject("len9");

        // alternating valid with ignored mid-frame cfg_we/start, then back-to-back frame
        set_cfg(PAT_MAX'(2'b11), 2);
        b = '0;
        b[3:0] = 4'b1111;
        do_frame(4, b, 1, 1'b1);
        for (int i = 0; i < 32; i++) b[i] = 1'($urandom_range(0, 1));
        do_frame(20, b, 2, 1'b0);

        // random configurations and frames
        for (int k = 0; k < 8; k++) begin
            set_cfg(PAT_MAX'($urandom), int'($urandom_range(1, PAT_MAX)));
            for (int i = 0; i < 64; i++) b[i] = 1'($urandom_range(0, 1));
            do_frame(int'($urandom_range(1, 60)), b, 2, 1'b0);
        end

        // match counter saturation
        set_cfg(PAT_MAX'(1'b1), 1);
        b = '1;
        do_frame(300, b, 0, 1'b0);
        check("sat_cnt", bus_if.match_cnt, 255);

        // reset after 3 of 8 bits
        set_cfg(PAT_MAX'(3'b101), 3);
        bus_if.start     = 1'b1;
        bus_if.frame_len = FRAME_W'(8);
        step();
        bus_if.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_if.x_valid = 1'b1;
            bus_if.x       = (i != 1);
            step();
        end
        bus_if.x_valid = 1'b0;
        check("pre_rst_cnt", bus_if.match_cnt, 1);
        rst = 1'b1;
        step();
        check_all_zero("midrst");
        rst = 1'b0;
        step();
        check_all_zero("postrst");
        m_pat = PAT_MAX'(2'b01);
        m_len = 2;
        b = '0;
        b[1:0] = 2'b10;
        do_frame(2, b, 0, 1'b0);
        check("rst_cfg_cnt", bus_if.match_cnt, 1);
        for (int i = 0; i < 32; i++) b[i] = 1'($urandom_range(0, 1));
        do_frame(24, b, 2, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

- Frame-level controller for a bit-serial pattern detector.
- Accepts a software-configured pattern (1..PAT_MAX bits) and a start command with a frame length, then pulls that many bits from a valid/ready serial stream.
- Each bit is fed through a shared match core; the controller pulses a hit on every match, accumulates a saturating match count and signals frame completion.
- Sits between the serial input source and the status logic, replacing hard-wired single-pattern FSM detectors.

## Interface
- PAT_MAX, 8, maximum pattern length in bits
- FRAME_W, 16, width of the frame-length field
- CNT_W, 8, width of the match counter
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  load cfg_pat/cfg_len; honoured only in IDLE
- cfg_pat  in  PAT_MAX  pattern; bit [cfg_len-1] is the first bit in time, bit 0 the last
- cfg_len  in  $clog2(PAT_MAX)+1  pattern length
- start  in  1  begin a frame; honoured only in IDLE
- frame_len  in  FRAME_W  number of bits in the frame, sampled on start
- x_valid  in  1  serial bit valid
- x  in  1  serial data bit
- x_ready  out  1  high only in RUN
- hit  out  1  one-cycle match pulse
- match_cnt  out  CNT_W  matches in the current or last frame
- busy  out  1  state != IDLE
- done  out  1  one-cycle end-of-frame pulse
- err  out  1  one-cycle pulse: start rejected because of invalid configuration

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - cfg_we latches cfg_pat and cfg_len.
  - start with stored length 0 or > PAT_MAX: err=1 for one cycle, remain in IDLE.
  - start with valid configuration:
    - clear the history register, fill counter and match_cnt.
    - load remaining = frame_len.
    - go to RUN, or to DONE directly if frame_len == 0.
- **RUN**
  - A bit is accepted when x_valid && x_ready.
  - On accept:
    - history shifts left, taking x in at bit 0.
    - fill counter increments, saturating at PAT_MAX.
    - remaining decrements.
  - A match is declared on the accept when:
    - fill, counting the new bit, >= cfg_len, and
    - the low cfg_len bits of the new history equal cfg_pat[cfg_len-1:0].
  - On a match:
    - hit=1 on the following cycle.
    - match_cnt increments, saturating at all-ones.
  - Accept with remaining == 1 goes to DONE.
  - Cycles with x_valid low do not advance remaining.
- **DONE**
  - done=1 for one cycle, then IDLE.
  - match_cnt holds its value until the next valid start.
- start is ignored in RUN and DONE; cfg_we is ignored in RUN and DONE.
- Reset values:
  - all outputs 0; state IDLE.
  - cfg_pat = 'b01 and cfg_len = 2, giving a "0 then 1" detector out of reset.
  - history, fill and remaining are 0.
- Reset mid-frame aborts the frame: no done pulse, match_cnt cleared.

## Timing
- x_ready is a registered state decode: high on the first cycle after the start edge and low on the cycle after the final accept.
- Latency from an accepted bit to its hit is exactly 1 cycle; match_cnt updates on the same edge that raises hit.
- Final bit of a matching frame: hit and done are high in the same cycle.
- frame_len == 0: done is high 1 cycle after the start edge, with match_cnt = 0.
- err rises 1 cycle after the rejected start.
- Back-to-back frames: a start in the cycle after done is honoured.

## Configuration
- OVERLAP_EN defined:
  - matches may overlap; fill is not cleared on a match.
  - pattern 101 on stream 10101 gives 2 matches.
- OVERLAP_EN undefined:
  - fill is cleared to 0 on every match, so the next match needs cfg_len fresh bits.
  - the same stream gives 1 match.

## Structure
- Shared package pattern_scan_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - PAT_MAX, FRAME_W and CNT_W defaults
  - reset constants RST_PAT = 'b01 and RST_LEN = 2
- One sub-module, pattern_match_core, contains:
  - the history shift register, fill counter and masked compare.
  - inputs: shift_en, bit, clr, pat, len.
  - output: a combinational match signal.
- The controller owns the FSM, remaining counter, match counter and output registers.

## Test plan
- Default config after reset; start, frame_len=5, bits 0,1,1,0,1 → hit one cycle after the 2nd and 5th accepts, match_cnt=2, done on the last hit cycle.
- cfg_pat=101, cfg_len=3, frame 1,0,1,0,1 → match_cnt=2 with OVERLAP_EN, 1 without.
- start with frame_len=0 → done one cycle later, match_cnt=0, x_ready never high.
- cfg_len=0, then start → err pulse, busy stays 0; cfg_len=9 with PAT_MAX=8 → same response.
- frame_len=4 with x_valid low on alternate cycles → exactly 4 accepts, done after the 4th; cfg_we and start asserted mid-frame have no effect.
- rst asserted after 3 of 8 bits → next cycle is IDLE with all outputs 0, no done pulse, cfg restored to 01/2.
